// File: rtl/seq_pkg.sv
// Shared types and constants for the fetch-path control sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive MEM-state cycles; flags the last allowed cycle
// without mem_ready so the sequencer can fault-halt.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Held at zero outside MEM, so every MEM entry starts from a clean count.
    always_comb begin
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (cnt_q != W'(MEM_TIMEOUT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = active && !mem_ready
                   && (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback control FSM with
// instruction register, retired-instruction counter and memory timeout.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int INSTR_W     = 32,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               mem_ready,
    output logic               pc_inc,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_load,
    output logic               mem_req,
    output logic               reg_write,
    output logic               halted,
    output logic               fault,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   instr_count
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic               expired;
    logic [5:0]         opcode;

    assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .active   (state_q == S_MEM),
        .mem_ready(mem_ready),
        .expired  (expired)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = rom_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A late mem_ready on the final allowed cycle still retires.
                if (mem_ready) begin
                    state_d = S_WB;
                end else if (expired) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_WB: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign pc_inc      = (state_q == S_WB);
    assign ir_load     = (state_q == S_DECODE);
    assign mem_req     = (state_q == S_MEM);
    assign reg_write   = (state_q == S_WB) && (opcode != OP_STORE);
    assign halted      = (state_q == S_HALT);
    assign fault       = fault_q;
    assign state       = state_q;
    assign ir          = ir_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: stimulus pushes expected retirements/halts, a
// negedge monitor pops and compares; ROM, PC and memory modelled here.
module tb_instr_sequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int INSTR_W     = 32;
    localparam int CNT_W       = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               run = 1'b0;
    logic               step = 1'b0;
    logic [INSTR_W-1:0] rom_data = '0;
    logic               mem_ready = 1'b0;
    logic               pc_inc;
    logic [INSTR_W-1:0] ir;
    logic               ir_load;
    logic               mem_req;
    logic               reg_write;
    logic               halted;
    logic               fault;
    logic [2:0]         state;
    logic [CNT_W-1:0]   instr_count;

    instr_sequencer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .INSTR_W    (INSTR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .rom_data   (rom_data),
        .mem_ready  (mem_ready),
        .pc_inc     (pc_inc),
        .ir         (ir),
        .ir_load    (ir_load),
        .mem_req    (mem_req),
        .reg_write  (reg_write),
        .halted     (halted),
        .fault      (fault),
        .state      (state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic        rw;
        int          cnt;
        int          lat;
        int          memc;
        logic        fault;
        logic        halt;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          memc = 0;
    int          mcnt = 0;
    int          ret = 0;
    int          ready_lat = 0;
    bit          halt_seen = 0;
    logic [7:0]  pc = '0;
    logic [31:0] rom [256];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_regop();
        logic [5:0] op;
        do begin
            op = 6'($urandom_range(0, 62));
        end while (op == 6'h23 || op == 6'h2B);
        return {op, 26'($urandom)};
    endfunction

    // Program counter and synchronous ROM
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) pc <= '0;
        else if (pc_inc) pc <= pc + 8'd1;
        rom_data <= rom[pc];
    end

    // Data memory: answers on the ready_lat-th MEM cycle, noise elsewhere
    always @(negedge clk) begin
        if (mem_req) begin
            mcnt = mcnt + 1;
            mem_ready = (mcnt == ready_lat);
        end else begin
            mcnt = 0;
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            memc = 0;
            halt_seen = 0;
        end else begin
            if (mem_req) memc++;
            if (pc_inc) begin
                if (q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("retire_not_halt", 0, e.halt);
                    chk("wb_ir", ir, e.ir);
                    chk("wb_reg_write", reg_write, e.rw);
                    chk("wb_count", instr_count, e.cnt);
                    chk("wb_latency", cyc - t0, e.lat);
                    chk("wb_mem_cycles", memc, e.memc);
                    chk("wb_fault", fault, 0);
                end
                memc = 0;
                if (run) t0 = cyc + 1;
            end
            if (halted && !halt_seen) begin
                halt_seen = 1;
                if (q.size() == 0) begin
                    chk("unexpected_halt", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("halt_expected", 1, e.halt);
                    chk("halt_ir", ir, e.ir);
                    chk("halt_fault", fault, e.fault);
                    chk("halt_latency", cyc - t0, e.lat);
                    chk("halt_count", instr_count, e.cnt);
                    chk("halt_mem_cycles", memc, e.memc);
                    chk("halt_state", state, 6);
                end
            end
        end
    end

    task automatic push(logic [31:0] i, logic rw, int lat, int mc,
                        logic f, logic h);
        exp_t e;
        e.ir = i; e.rw = rw; e.cnt = ret; e.lat = lat;
        e.memc = mc; e.fault = f; e.halt = h;
        if (!h) ret++;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        step = 1'b0;
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_pc_inc", pc_inc, 0);
        chk("rst_ir_load", ir_load, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ir", ir, 0);
        chk("rst_count", instr_count, 0);
        q.delete();
        ret = 0;
        ready_lat = 0;
        reset = 1'b0;
    endtask

    task automatic wait_drain(int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic wait_state(logic [2:0] s, int maxc);
        int n = 0;
        while (state !== s && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", state, s);
    endtask

    // kind: 0 reg, 1 load, 2 store, 3 halt opcode; k=0 means no mem_ready
    task automatic step_one(int kind, int k, bit extra_step);
        logic [31:0] i;
        int          mc;
        i = rand_regop();
        if (kind == 1) i[31:26] = 6'h23;
        if (kind == 2) i[31:26] = 6'h2B;
        if (kind == 3) i = 32'hFC00_0000;
        mc = (kind == 1 || kind == 2) ? ((k == 0) ? MEM_TIMEOUT : k) : 0;
        rom[pc] = i;
        ready_lat = k;
        if (kind == 3) push(i, 1'b0, 3, 0, 1'b0, 1'b1);
        else if (mc != 0 && k == 0) push(i, 1'b0, 3 + mc, mc, 1'b1, 1'b1);
        else push(i, kind != 2, 3 + mc, mc, 1'b0, 1'b0);
        step = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        step = 1'b0;
        if (extra_step) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            if (state != 3'd0) begin
                step = 1'b1;
                @(negedge clk);
                step = 1'b0;
            end
        end
    endtask

    task automatic halt_hold();
        repeat (8) begin
            run = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        run = 1'b0;
        step = 1'b0;
        chk("hold_state", state, 6);
        chk("hold_halted", halted, 1);
        chk("hold_count", instr_count, ret);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) rom[i] = rand_regop();
        @(negedge clk);
        do_reset();

        // Free run of register ops, step asserted alongside run at start
        for (int i = 0; i < 6; i++) begin
            rom[8'(pc + 8'(i))] = rand_regop();
            push(rom[8'(pc + 8'(i))], 1'b1, 3, 0, 1'b0, 1'b0);
        end
        run = 1'b1;
        step = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        step = 1'b0;
        n = 0;
        while (q.size() > 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        run = 1'b0;
        wait_drain(40);
        repeat (2) @(negedge clk);
        chk("run_end_idle", state, 0);
        chk("run_count", instr_count, ret);

        // Single steps: directed store/load, then random mix
        step_one(2, 1, 1'b0);
        wait_drain(40);
        step_one(1, 3, 1'b1);
        wait_drain(40);
        repeat (2) @(negedge clk);
        chk("step_idle", state, 0);
        for (int i = 0; i < 20; i++) begin
            step_one($urandom_range(0, 2), $urandom_range(1, 6),
                     1'($urandom_range(0, 1)));
            wait_drain(60);
            repeat (2) @(negedge clk);
            chk("rand_idle", state, 0);
        end
        chk("step_count", instr_count, ret);

        // Timeout boundary: ready on last allowed cycle, then never
        step_one(1, MEM_TIMEOUT, 1'b0);
        wait_drain(60);
        repeat (2) @(negedge clk);
        step_one(1, 0, 1'b0);
        wait_drain(60);
        halt_hold();
        chk("hold_fault", fault, 1);
        do_reset();

        // HALT opcode
        step_one(3, 0, 1'b0);
        wait_drain(40);
        halt_hold();
        chk("halt_op_fault", fault, 0);
        do_reset();

        // Reset mid-MEM, then a full timeout must take the whole budget
        rom[pc] = {6'h23, 26'($urandom)};
        ready_lat = 0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_state(3'd4, 20);
        repeat (8) @(negedge clk);
        chk("mid_mem_req", mem_req, 1);
        do_reset();
        step_one(1, 0, 1'b0);
        wait_drain(60);
        do_reset();

        // Reset during WB
        step_one(0, 0, 1'b0);
        wait_state(3'd5, 20);
        do_reset();
        step_one(0, 0, 1'b0);
        wait_drain(40);
        repeat (2) @(negedge clk);
        chk("post_reset_count", instr_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
